safe_lock: RTL and testbench

- Consumer stage directly downstream of the button/dial step decoder in the safe design.
- Receives one step pulse per dial click (`cnten` active-low, with `up` and `dirch` qualifiers) and keeps the dial position modulo `DIAL_SIZE`.
- Checks a 3-number combination entered by direction reversals, followed by pulling the handle.
- Drives the open/error/alarm indicators, and enforces a lockout after repeated failed attempts.

---
 rtl/safe_pkg.sv | 29 ++
 rtl/dial_counter.sv | 40 ++++
 rtl/safe_lock.sv | 153 +++++++++++++++
 tb/tb_safe_lock.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Shared definitions for the combination safe: lock FSM encoding and default dial/code constants.
package safe_pkg;

   localparam int DEF_DIAL_SIZE   = 10;
   localparam int DEF_POS_W       = 4;
   localparam int DEF_CODE0       = 3;
   localparam int DEF_CODE1       = 7;
   localparam int DEF_CODE2       = 1;
   localparam int DEF_MAX_FAIL    = 3;
   localparam int DEF_LOCKOUT_CYC = 16;

   typedef enum logic [2:0] {
      ST_L0    = 3'd0,
      ST_L1    = 3'd1,
      ST_L2    = 3'd2,
      ST_OPEN  = 3'd3,
      ST_ALARM = 3'd4
   } lock_state_t;

   // Number of combination digits already accepted; OPEN and ALARM report 0.
   function automatic logic [1:0] stage_of(input lock_state_t s);
      case (s)
         ST_L1:   stage_of = 2'd1;
         ST_L2:   stage_of = 2'd2;
         default: stage_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/dial_counter.sv
// Modulo-DIAL_SIZE up/down dial position register; freeze holds the position regardless of steps.
module dial_counter
   import safe_pkg::*;
#(
   parameter int DIAL_SIZE = DEF_DIAL_SIZE,
   parameter int POS_W     = DEF_POS_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             up,
   input  logic             freeze,
   output logic [POS_W-1:0] pos
);

   localparam logic [POS_W-1:0] POS_MAX = POS_W'(DIAL_SIZE - 1);

   logic [POS_W-1:0] pos_next;

   // Wrap on DIAL_SIZE, not on the natural width of the register.
   always_comb begin
      pos_next = pos;
      if (step && !freeze) begin
         if (up) begin
            pos_next = (pos == POS_MAX) ? '0 : pos + POS_W'(1);
         end else begin
            pos_next = (pos == '0) ? POS_MAX : pos - POS_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos <= '0;
      end else begin
         pos <= pos_next;
      end
   end

endmodule

// File: rtl/safe_lock.sv
// Combination safe controller: dial position, 3-number combination FSM, handle edge detect,
// failed-attempt counting and timed alarm lockout. All outputs are registered.
module safe_lock
   import safe_pkg::*;
#(
   parameter int DIAL_SIZE   = DEF_DIAL_SIZE,
   parameter int POS_W       = DEF_POS_W,
   parameter int CODE0       = DEF_CODE0,
   parameter int CODE1       = DEF_CODE1,
   parameter int CODE2       = DEF_CODE2,
   parameter int MAX_FAIL    = DEF_MAX_FAIL,
   parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnten,
   input  logic             up,
   input  logic             dirch,
   input  logic             handle,
   input  logic             close,
   output logic [POS_W-1:0] pos,
   output logic [1:0]       stage,
   output logic             opened,
   output logic             err,
   output logic             alarm
);

   localparam int FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

   localparam logic [POS_W-1:0]  C0        = POS_W'(CODE0);
   localparam logic [POS_W-1:0]  C1        = POS_W'(CODE1);
   localparam logic [POS_W-1:0]  C2        = POS_W'(CODE2);
   localparam logic [FAIL_W-1:0] LAST_FAIL = FAIL_W'(MAX_FAIL - 1);
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYC);

   lock_state_t       state;
   lock_state_t       next_state;
   logic              handle_q;
   logic              step;
   logic              hedge;
   logic              fail_evt;
   logic [FAIL_W-1:0] fail_cnt;
   logic [LOCK_W-1:0] lock_cnt;
   logic [1:0]        stage_d;
   logic              opened_d;
   logic              alarm_d;
   logic              err_d;

   assign step  = ~cnten;
   assign hedge = handle & ~handle_q;

   dial_counter #(
      .DIAL_SIZE (DIAL_SIZE),
      .POS_W     (POS_W)
   ) u_dial (
      .clk    (clk),
      .rst    (rst),
      .step   (step),
      .up     (up),
      .freeze (state == ST_ALARM),
      .pos    (pos)
   );

   // State register plus registered copies of every output and the bookkeeping counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_L0;
         handle_q <= 1'b0;
         fail_cnt <= '0;
         lock_cnt <= '0;
         stage    <= 2'd0;
         opened   <= 1'b0;
         err      <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         state    <= next_state;
         handle_q <= handle;
         stage    <= stage_d;
         opened   <= opened_d;
         err      <= err_d;
         alarm    <= alarm_d;

         if (fail_evt) begin
            fail_cnt <= fail_cnt + FAIL_W'(1);
         end else if (next_state == ST_OPEN ||
                      (state == ST_OPEN  && next_state == ST_L0) ||
                      (state == ST_ALARM && next_state == ST_L0)) begin
            fail_cnt <= '0;
         end

         if (fail_evt && next_state == ST_ALARM) begin
            lock_cnt <= LOCK_LOAD;
         end else if (state == ST_ALARM && lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
         end
      end
   end

   // A step in the same cycle as a handle edge takes priority; the edge is dropped.
   always_comb begin
      next_state = state;
      fail_evt   = 1'b0;
      case (state)
         ST_L0: begin
            if (step) begin
               if (dirch) begin
                  if (!up && pos == C0) next_state = ST_L1;
                  else                  fail_evt   = 1'b1;
               end
            end else if (hedge) begin
               fail_evt = 1'b1;
            end
         end
         ST_L1: begin
            if (step) begin
               if (dirch) begin
                  if (up && pos == C1) next_state = ST_L2;
                  else                 fail_evt   = 1'b1;
               end
            end else if (hedge) begin
               fail_evt = 1'b1;
            end
         end
         ST_L2: begin
            if (step) begin
               if (dirch) fail_evt = 1'b1;
            end else if (hedge) begin
               if (pos == C2) next_state = ST_OPEN;
               else           fail_evt   = 1'b1;
            end
         end
         ST_OPEN: begin
            if (close) next_state = ST_L0;
         end
         ST_ALARM: begin
            if (lock_cnt <= LOCK_W'(1)) next_state = ST_L0;
         end
         default: next_state = ST_L0;
      endcase
      if (fail_evt) begin
         next_state = (fail_cnt == LAST_FAIL) ? ST_ALARM : ST_L0;
      end
   end

   always_comb begin
      stage_d  = stage_of(next_state);
      opened_d = (next_state == ST_OPEN);
      alarm_d  = (next_state == ST_ALARM);
      err_d    = fail_evt;
   end

endmodule

// File: tb/tb_safe_lock.sv
// Directed bench for safe_lock: dial wrap, combination entry, failures, lockout, handle/close cases, async reset.
module tb_safe_lock;

   logic       clk = 1'b0;
   logic       rst;
   logic       cnten;
   logic       up;
   logic       dirch;
   logic       handle;
   logic       close;
   logic [3:0] pos;
   logic [1:0] stage;
   logic       opened;
   logic       err;
   logic       alarm;

   int checks = 0;
   int errors = 0;

   safe_lock dut (
      .clk    (clk),
      .rst    (rst),
      .cnten  (cnten),
      .up     (up),
      .dirch  (dirch),
      .handle (handle),
      .close  (close),
      .pos    (pos),
      .stage  (stage),
      .opened (opened),
      .err    (err),
      .alarm  (alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_step(input logic u, input logic d);
      cnten = 1'b0;
      up    = u;
      dirch = d;
      tick();
      cnten = 1'b1;
      dirch = 1'b0;
   endtask

   task automatic steps(input logic u, input int n);
      for (int i = 0; i < n; i++) do_step(u, 1'b0);
   endtask

   // From pos=3 in L0: reverse down (accept 3), 5 down to 7, reverse up (accept 7) -> L2 at pos 8.
   task automatic enter_to_l2();
      do_step(1'b0, 1'b1);
      check("l1_stage", stage, 1);
      check("l1_pos", pos, 2);
      steps(1'b0, 5);
      check("pos_at_7", pos, 7);
      do_step(1'b1, 1'b1);
      check("l2_stage", stage, 2);
      check("l2_pos", pos, 8);
   endtask

   initial begin
      rst = 1'b1; cnten = 1'b1; up = 1'b0; dirch = 1'b0; handle = 1'b0; close = 1'b0;
      tick();
      tick();
      check("rst_pos", pos, 0);
      check("rst_stage", stage, 0);
      check("rst_opened", opened, 0);
      check("rst_err", err, 0);
      check("rst_alarm", alarm, 0);
      rst = 1'b0;

      // Dial wrap in both directions.
      do_step(1'b0, 1'b0);
      check("wrap_down", pos, 9);
      do_step(1'b1, 1'b0);
      check("wrap_up", pos, 0);
      check("wrap_stage", stage, 0);

      // Correct combination.
      steps(1'b1, 3);
      check("combo_pos3", pos, 3);
      enter_to_l2();
      steps(1'b1, 3);
      check("combo_pos1", pos, 1);
      check("combo_err_before", err, 0);
      handle = 1'b1;
      tick();
      check("open_opened", opened, 1);
      check("open_stage", stage, 0);
      check("open_err", err, 0);
      handle = 1'b0;
      close = 1'b1;
      tick();
      check("close_opened", opened, 0);
      close = 1'b0;

      // Wrong first number from reset.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      steps(1'b1, 4);
      check("wrong_pos4", pos, 4);
      do_step(1'b0, 1'b1);
      check("wrong_err", err, 1);
      check("wrong_stage", stage, 0);
      check("wrong_opened", opened, 0);
      check("wrong_pos", pos, 3);
      tick();
      check("wrong_err_clear", err, 0);

      // Second failure by handle in L0, third by wrong-direction reversal -> alarm.
      handle = 1'b1;
      tick();
      check("fail2_err", err, 1);
      check("fail2_alarm", alarm, 0);
      handle = 1'b0;
      tick();
      do_step(1'b1, 1'b1);
      check("fail3_err", err, 1);
      check("fail3_alarm", alarm, 1);
      check("fail3_pos", pos, 4);
      for (int i = 1; i < 16; i++) begin
         do_step(1'b1, 1'b0);
         check("lock_alarm", alarm, 1);
         check("lock_pos", pos, 4);
         check("lock_err", err, 0);
      end
      tick();
      check("lock_expire_alarm", alarm, 0);
      check("lock_expire_stage", stage, 0);
      check("lock_expire_pos", pos, 4);

      // Correct combination after lockout, then close together with a step.
      do_step(1'b0, 1'b0);
      check("post_lock_pos3", pos, 3);
      enter_to_l2();
      steps(1'b1, 3);
      handle = 1'b1;
      tick();
      check("post_lock_opened", opened, 1);
      handle = 1'b0;
      close = 1'b1;
      do_step(1'b1, 1'b0);
      check("close_step_opened", opened, 0);
      check("close_step_pos", pos, 2);
      close = 1'b0;

      // Handle at wrong position in L2.
      do_step(1'b1, 1'b0);
      enter_to_l2();
      steps(1'b1, 4);
      check("l2_pos2", pos, 2);
      handle = 1'b1;
      tick();
      check("l2_bad_err", err, 1);
      check("l2_bad_stage", stage, 0);
      handle = 1'b0;
      tick();
      check("l2_bad_err_clear", err, 0);

      // Handle rise coincident with a step is dropped; close outside OPEN is ignored.
      do_step(1'b1, 1'b0);
      enter_to_l2();
      steps(1'b1, 3);
      handle = 1'b1;
      do_step(1'b1, 1'b0);
      check("coinc_err", err, 0);
      check("coinc_pos", pos, 2);
      check("coinc_stage", stage, 2);
      tick();
      check("coinc_err_later", err, 0);
      check("coinc_opened", opened, 0);
      handle = 1'b0;
      close = 1'b1;
      tick();
      check("close_in_l2_stage", stage, 2);
      close = 1'b0;

      // Asynchronous reset while in L2.
      #2;
      rst = 1'b1;
      #1;
      check("arst_l2_pos", pos, 0);
      check("arst_l2_stage", stage, 0);
      rst = 1'b0;
      tick();

      // Three handle failures, then asynchronous reset during the alarm.
      for (int i = 0; i < 3; i++) begin
         handle = 1'b1;
         tick();
         check("hfail_err", err, 1);
         handle = 1'b0;
         tick();
      end
      check("hfail_alarm", alarm, 1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_alarm_alarm", alarm, 0);
      check("arst_alarm_err", err, 0);
      check("arst_alarm_pos", pos, 0);
      check("arst_alarm_stage", stage, 0);
      rst = 1'b0;
      tick();
      check("post_arst_alarm", alarm, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
